// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states,
// byte/half lane selection and request legality.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  function automatic logic [7:0] f_byte_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] f_half_lane(input logic [31:0] word, input logic upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic f_req_err(input logic we, input logic [2:0] f3, input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = we ? (f3 >= 3'd3) : ((f3 == 3'd3) || (f3 >= 3'd6));
    misaligned = ((f3[1:0] == 2'd1) && addr_lo[0]) || ((f3[1:0] == 2'd2) && (addr_lo != 2'd0));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word and
// merges store data into a RAM word for read-modify-write.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = f_byte_lane(rword, addr_lo);
  assign w_half = f_half_lane(rword, addr_lo[1]);

  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data = {24'd0, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data = {16'd0, w_half};
      F3_W:    load_data = rword;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged_word = rword;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    merged_word[7:0]   = wdata[7:0];
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          default: merged_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      F3_W:    merged_word = wdata;
      default: merged_word = rword;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between execute stage and a word-wide, async-read RAM:
// sub-word stores via read-modify-write, loads extracted and extended.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_funct3;
  logic [1:0]          r_addr_lo;
  logic [31:0]         r_wdata;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic [31:0]         r_ram_din;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic                w_accept;
  logic                w_req_err;
  logic [31:0]         w_load_data;
  logic [31:0]         w_merged;
  logic                w_unused_addr_hi;

  // Upper byte-address bits alias onto the RAM and are deliberately dropped.
  assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_req_err = f_req_err(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .addr_lo     (r_addr_lo),
    .funct3      (r_funct3),
    .wdata       (r_wdata),
    .rword       (ram_dout),
    .load_data   (w_load_data),
    .merged_word (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = (r_state == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                  w_next_state = S_RESP;
          else if (!req_we)               w_next_state = S_RD;
          else if (req_funct3 == F3_W)    w_next_state = S_WR;
          else                            w_next_state = S_RMW_RD;
        end
      end
      S_RD:     w_next_state = S_RESP;
      S_RMW_RD: w_next_state = S_WR;
      S_WR:     w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with WR/RESP exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_wdata     <= 32'd0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_din   <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_ram_we    <= (w_next_state == S_WR);
      r_rsp_valid <= (w_next_state == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3   <= req_funct3;
            r_addr_lo  <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_ram_addr <= req_addr[ADDR_W+1:2];
            if (w_req_err) begin
              r_rsp_rdata <= 32'd0;
              r_rsp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              r_ram_din <= req_wdata;
            end
          end
        end
        S_RD: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_err   <= 1'b0;
        end
        S_RMW_RD: r_ram_din <= w_merged;
        S_WR: begin
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_din   = r_ram_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
